serial_addsub_ctrl: RTL

//  Bit-serial sequencer that feeds one addsub cell, LSB first.

---
 rtl/serial_pkg.sv | 13 +
 rtl/serial_shreg.sv | 25 ++
 rtl/serial_addsub_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared encodings for the bit-serial add/subtract sequencer.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_shreg.sv
// Parallel-load right-shift register with serial fill at the MSB end.
// Load wins over shift; one cycle per operation, no backpressure.
module serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial LSB-first sequencer around an external addsub cell; done pulses WIDTH+1 cycles after start.
// start is only accepted in IDLE/DONE; a start during a run is dropped.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             as_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
  output logic             overflow,
  output logic             cell_A,
  output logic             cell_B,
  output logic             cell_cin,
  output logic             cell_AS,
  input  logic             cell_sum,
  input  logic             cell_cout
);
  import serial_pkg::*;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic             as_q;
  logic             run;
  logic             accept;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             unused_sh;

  assign run    = (state == S_RUN);
  assign accept = start && !run;

  serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .resetb(resetb), .load(accept), .shift(run),
    .sin(1'b0), .din(a_in), .q(a_sh)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .resetb(resetb), .load(accept), .shift(run),
    .sin(1'b0), .din(b_in), .q(b_sh)
  );

  // Result fills from the MSB end; never parallel-loaded so it holds between runs.
  serial_shreg #(.WIDTH(WIDTH)) u_res_sh (
    .clk(clk), .resetb(resetb), .load(1'b0), .shift(run),
    .sin(cell_sum), .din('0), .q(result)
  );

  // Only the LSB of each operand register feeds the cell.
  assign unused_sh = ^{a_sh[WIDTH-1:1], b_sh[WIDTH-1:1]};

  assign cell_A   = run & a_sh[0];
  assign cell_B   = run & b_sh[0];
  assign cell_cin = run & carry_q;
  assign cell_AS  = run & as_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cout_out <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      carry_q  <= 1'b0;
      as_q     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          carry_q <= cell_cout;
          if (cnt == LAST) begin
            // carry_q is the carry into the MSB here, cell_cout the carry out of it.
            cnt      <= '0;
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cout_out <= cell_cout;
            overflow <= carry_q ^ cell_cout;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (start) begin
            // Subtract seeds the carry with 1 to complete the two's complement of B.
            state   <= S_RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
            as_q    <= as_in;
            carry_q <= as_in;
            cnt     <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
